cromatic_sequencer: RTL and testbench
=====================================

Name: cromatic_sequencer

Overview:
- Generates the three PWM drive signals (red, green, blue) that feed the RGB LED matrix fan-out stage.
- Sweeps automatically around the full hue wheel in six linear ramp phases, with a global brightness scale.
- Supports run/pause and single-step control so the whole chromatic palette can be shown, frozen or stepped through.
- Sits between the board clock and the matrix fan-out; one instance drives all 25 LEDs.

Parameters:
- PWM_BITS, 8, width of the PWM counter, duties, ramp and brightness; MAX = 2^PWM_BITS-1.
- STEP_DIV, 19531, clock cycles per ramp step; must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- run  input  1  1 = auto-advance the hue sweep; 0 = paused
- step  input  1  single-cycle pulse; advances one ramp step while run=0
- bright  input  PWM_BITS  global brightness scale
- R_pwm_output  output  1  red PWM drive
- G_pwm_output  output  1  green PWM drive
- B_pwm_output  output  1  blue PWM drive
- phase  output  3  current hue phase, 0..5
- sweep_done  output  1  one-cycle pulse when phase 5 completes

Behaviour:
- Reset is sampled on the clk rising edge with rst_n=0. All of the following return to 0: cnt, step timer, phase, ramp, the active duties, all PWM outputs and sweep_done.
- PWM counter cnt (PWM_BITS wide) free-runs from 0 to MAX, then wraps to 0. It is never gated by run.
- Step tick:
  - With run=1, the step timer counts 0..STEP_DIV-1. The tick is asserted in the cycle the timer equals STEP_DIV-1, and the timer then wraps to 0.
  - With run=0, the timer holds its value. A tick is asserted in any cycle step=1.
  - With run=1, step is ignored.
- Ramp and phase:
  - On a tick with ramp<MAX: ramp increments by 1.
  - On a tick with ramp=MAX: ramp goes to 0 and phase advances (5 wraps to 0).
  - On the 5->0 transition, sweep_done=1 for exactly that cycle.
- Target duties per phase (r = ramp):
  - P0: R=MAX, G=r, B=0
  - P1: R=MAX-r, G=MAX, B=0
  - P2: R=0, G=MAX, B=r
  - P3: R=0, G=MAX-r, B=MAX
  - P4: R=r, G=0, B=MAX
  - P5: R=MAX, G=0, B=MAX-r
- Phase boundaries are continuous: no channel jumps at a phase change.
- Brightness scaling:
  - scaled = (target * (bright+1)) >> PWM_BITS, using a 2*PWM_BITS+1-bit intermediate.
  - bright=MAX gives scaled = target exactly.
  - bright=0 gives 0 for all targets.
- Glitch-free update: the active duties load the scaled values only in the cycle cnt=MAX. Ramp, phase or bright changes never take effect mid-period.
- Output timing:
  - Each output is registered: X_pwm_output <= (cnt < duty_act_X), using pre-edge values.
  - Latency is 1 clk from the counter to the output.
  - duty=0 means the output is always low. duty=MAX means high MAX of every 2^PWM_BITS cycles.
- Simultaneous events:
  - A tick in the cycle cnt=MAX updates ramp/phase on the same edge; the load that edge uses the pre-tick ramp.
  - The new ramp value is loaded at the next wrap.
- Mid-operation reset: rst_n=0 at any point returns the block to the reset state on the next edge, with outputs low.
- After reset, the first load (cnt=MAX) sets R to the scaled MAX, and G and B to 0.
- run toggling:
  - Pausing preserves the timer, ramp and phase.
  - Resuming continues from the held timer value.

Test Plan:
- Reset/first load (PWM_BITS=4, STEP_DIV=4, bright=15, run=0): hold rst_n=0 then release.
  - All outputs must stay 0 through cnt 0..15.
  - From the next period, R is high 15 of 16 cycles, and G and B stay low.
- Auto sweep (run=1, STEP_DIV=4, PWM_BITS=4):
  - phase must advance every 64 clk: 0,1,2,3,4,5,0.
  - sweep_done must pulse exactly once, at the 384th tick-edge.
  - Sampled duties at phase boundaries must be continuous.
- Brightness (bright=7, phase 0, ramp=0): R duty_act must be (15*8)>>4 = 7, giving R high 7 of 16 cycles. With bright=0, all outputs stay low.
- Glitch-free (change bright 15->3 at cnt=5): the R high-time must stay 15 for the current period and become 3 in the next period.
- Pause/step (run=0): hold 100 clk and check ramp is unchanged.
  - Pulse step 16 times and check phase goes 0->1 and ramp returns to 0.
  - Assert step together with run=1 and check that no extra advance occurs.
- Reset mid-sweep (phase 3): assert rst_n=0 for one clk. phase, ramp and all outputs must be 0 on the next edge, and the first load must repeat the reset-load values.

Source files
------------

// File: rtl/cromatic_sequencer.sv
// RGB hue-wheel PWM generator: six linear ramp phases, global brightness scale,
// duty updates only at PWM period boundaries so the outputs never glitch.
module cromatic_sequencer #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 19531
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                step,
  input  logic [PWM_BITS-1:0] bright,
  output logic                R_pwm_output,
  output logic                G_pwm_output,
  output logic                B_pwm_output,
  output logic [2:0]          phase,
  output logic                sweep_done
);

  localparam logic [PWM_BITS-1:0] Max       = '1;
  localparam int unsigned         TimerW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TimerW-1:0]   TimerLast = TimerW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    StP0 = 3'd0,
    StP1 = 3'd1,
    StP2 = 3'd2,
    StP3 = 3'd3,
    StP4 = 3'd4,
    StP5 = 3'd5
  } phase_e;

  phase_e              phase_q, phase_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] tgt_r, tgt_g, tgt_b;
  logic [PWM_BITS-1:0] duty_r_q, duty_g_q, duty_b_q;
  logic                r_pwm_q, g_pwm_q, b_pwm_q;
  logic                sweep_done_q;
  logic                tick;
  logic                ramp_wrap;

  // (t * (b + 1)) >> PWM_BITS, written as t*b + t to keep every operand the same width.
  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] t,
                                                input logic [PWM_BITS-1:0] b);
    logic [2*PWM_BITS:0] p;
    p = ({{(PWM_BITS+1){1'b0}}, t} * {{(PWM_BITS+1){1'b0}}, b})
      + {{(PWM_BITS+1){1'b0}}, t};
    return p[2*PWM_BITS-1:PWM_BITS];
  endfunction

  // While paused the timer freezes and only the step pulse can advance the ramp.
  assign tick      = run ? (timer_q == TimerLast) : step;
  assign ramp_wrap = tick && (ramp_q == Max);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= StP0;
      ramp_q  <= '0;
      timer_q <= '0;
    end else begin
      phase_q <= phase_d;
      ramp_q  <= ramp_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    phase_d = phase_q;
    ramp_d  = ramp_q;
    timer_d = timer_q;
    if (run) begin
      timer_d = tick ? '0 : timer_q + 1'b1;
    end
    if (tick) begin
      if (ramp_wrap) begin
        ramp_d = '0;
        unique case (phase_q)
          StP0:    phase_d = StP1;
          StP1:    phase_d = StP2;
          StP2:    phase_d = StP3;
          StP3:    phase_d = StP4;
          StP4:    phase_d = StP5;
          StP5:    phase_d = StP0;
          default: phase_d = StP0;
        endcase
      end else begin
        ramp_d = ramp_q + 1'b1;
      end
    end
  end

  // Output logic: per-phase target duties
  always_comb begin
    tgt_r = '0;
    tgt_g = '0;
    tgt_b = '0;
    unique case (phase_q)
      StP0: begin tgt_r = Max;          tgt_g = ramp_q;       tgt_b = '0;           end
      StP1: begin tgt_r = Max - ramp_q; tgt_g = Max;          tgt_b = '0;           end
      StP2: begin tgt_r = '0;           tgt_g = Max;          tgt_b = ramp_q;       end
      StP3: begin tgt_r = '0;           tgt_g = Max - ramp_q; tgt_b = Max;          end
      StP4: begin tgt_r = ramp_q;       tgt_g = '0;           tgt_b = Max;          end
      StP5: begin tgt_r = Max;          tgt_g = '0;           tgt_b = Max - ramp_q; end
      default: begin tgt_r = '0;        tgt_g = '0;           tgt_b = '0;           end
    endcase
  end

  // PWM datapath; duties reload only on the last count of each period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      duty_r_q     <= '0;
      duty_g_q     <= '0;
      duty_b_q     <= '0;
      r_pwm_q      <= 1'b0;
      g_pwm_q      <= 1'b0;
      b_pwm_q      <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_q + 1'b1;
      r_pwm_q      <= cnt_q < duty_r_q;
      g_pwm_q      <= cnt_q < duty_g_q;
      b_pwm_q      <= cnt_q < duty_b_q;
      sweep_done_q <= ramp_wrap && (phase_q == StP5);
      if (cnt_q == Max) begin
        duty_r_q <= scale(tgt_r, bright);
        duty_g_q <= scale(tgt_g, bright);
        duty_b_q <= scale(tgt_b, bright);
      end
    end
  end

  assign R_pwm_output = r_pwm_q;
  assign G_pwm_output = g_pwm_q;
  assign B_pwm_output = b_pwm_q;
  assign phase        = phase_q;
  assign sweep_done   = sweep_done_q;

endmodule

// File: tb/tb_cromatic_sequencer.sv
// Bench for cromatic_sequencer: hue-index reference model checked every cycle,
// plus directed period high-time counts for reset, brightness, glitch-free and step.
module tb_cromatic_sequencer;

  localparam int PW   = 4;
  localparam int SDIV = 4;
  localparam int Span = 1 << PW;
  localparam int Max  = Span - 1;
  localparam int Hues = 6 * Span;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          step;
  logic [PW-1:0] bright;
  logic          r_pwm, g_pwm, b_pwm;
  logic [2:0]    phase;
  logic          sweep_done;

  int n_checks = 0;
  int n_errors = 0;

  cromatic_sequencer #(.PWM_BITS(PW), .STEP_DIV(SDIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .step         (step),
    .bright       (bright),
    .R_pwm_output (r_pwm),
    .G_pwm_output (g_pwm),
    .B_pwm_output (b_pwm),
    .phase        (phase),
    .sweep_done   (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Red level around the wheel; green and blue are the same curve shifted by two
  // and four phases respectively.
  function automatic int red_level(input int x);
    int seg = x / Span;
    int r   = x % Span;
    if (seg == 0 || seg == 5) return Max;
    if (seg == 1) return Max - r;
    if (seg == 4) return r;
    return 0;
  endfunction

  function automatic int scale(input int t, input int b);
    return (t * (b + 1)) / Span;
  endfunction

  // Reference model: one hue index 0..Hues-1 replaces ramp+phase.
  int m_cnt, m_timer, m_h, m_dr, m_dg, m_db;
  int m_r, m_g, m_b, m_done;

  always @(posedge clk) begin : model
    bit tick;
    if (!rst_n) begin
      m_cnt = 0; m_timer = 0; m_h = 0;
      m_dr = 0; m_dg = 0; m_db = 0;
      m_r = 0; m_g = 0; m_b = 0; m_done = 0;
    end else begin
      tick = run ? (m_timer == SDIV - 1) : step;
      m_r = (m_cnt < m_dr);
      m_g = (m_cnt < m_dg);
      m_b = (m_cnt < m_db);
      if (m_cnt == Max) begin
        m_dr = scale(red_level(m_h), int'(bright));
        m_dg = scale(red_level((m_h + 4 * Span) % Hues), int'(bright));
        m_db = scale(red_level((m_h + 2 * Span) % Hues), int'(bright));
      end
      m_done = (tick && m_h == Hues - 1);
      if (run) m_timer = tick ? 0 : m_timer + 1;
      if (tick) m_h = (m_h + 1) % Hues;
      m_cnt = (m_cnt + 1) % Span;
    end
  end

  // Advance one clock and compare every output against the model.
  task automatic cycle();
    @(negedge clk);
    check("r_pwm", r_pwm, m_r);
    check("g_pwm", g_pwm, m_g);
    check("b_pwm", b_pwm, m_b);
    check("phase", phase, m_h / Span);
    check("sweep_done", sweep_done, m_done);
  endtask

  // Count high samples over one full PWM period; optionally change bright mid-period.
  task automatic count_period(input int chg_idx, input logic [PW-1:0] chg_val,
                              output int nr, output int ng, output int nb);
    nr = 0; ng = 0; nb = 0;
    for (int k = 0; k < Span + 1 && m_cnt != 1; k++) cycle();
    for (int i = 0; i < Span; i++) begin
      if (i > 0) cycle();
      if (i == chg_idx) bright = chg_val;
      nr += r_pwm; ng += g_pwm; nb += b_pwm;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    check("rst_phase", phase, 0);
    check("rst_r", r_pwm, 0);
    rst_n = 1'b1;
  endtask

  int nr, ng, nb, pulses, pulse_at;

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; bright = 4'd15;
    repeat (3) cycle();
    rst_n = 1'b1;

    // First period after reset stays dark, next one shows red only.
    count_period(-1, 4'd0, nr, ng, nb);
    check("first_per_rgb", nr + ng + nb, 0);
    count_period(-1, 4'd0, nr, ng, nb);
    check("load_r", nr, 15);
    check("load_g", ng, 0);
    check("load_b", nb, 0);

    // Bright change at cnt=5 only lands in the following period.
    count_period(4, 4'd3, nr, ng, nb);
    check("glitch_cur_r", nr, 15);
    count_period(-1, 4'd0, nr, ng, nb);
    check("glitch_next_r", nr, 3);

    bright = 4'd7;
    count_period(-1, 4'd0, nr, ng, nb);
    count_period(-1, 4'd0, nr, ng, nb);
    check("bright7_r", nr, 7);
    bright = 4'd0;
    count_period(-1, 4'd0, nr, ng, nb);
    count_period(-1, 4'd0, nr, ng, nb);
    check("bright0_rgb", nr + ng + nb, 0);

    // Paused hold, then single steps through one full ramp.
    bright = 4'd15;
    repeat (100) cycle();
    check("pause_phase", phase, 0);
    repeat (Span) begin
      step = 1'b1; cycle();
      step = 1'b0; cycle();
    end
    check("step_phase", phase, 1);
    check("step_hue", m_h, Span);
    run = 1'b1; step = 1'b1;
    repeat (SDIV - 1) cycle();
    check("run_step_ignored", m_h, Span);
    step = 1'b0; run = 1'b0;

    // Full automatic sweep from reset.
    do_reset();
    run = 1'b1;
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= Hues * SDIV + 20; i++) begin
      cycle();
      if (i % (Span * SDIV) == 0) check("sweep_phase", phase, (i / (Span * SDIV)) % 6);
      if (sweep_done) begin
        pulses++;
        pulse_at = i;
      end
    end
    check("sweep_pulses", pulses, 1);
    check("sweep_pulse_at", pulse_at, Hues * SDIV);

    // Reset in the middle of phase 3 repeats the reset-load sequence.
    for (int k = 0; k < Hues * SDIV && m_h != 3 * Span + 5; k++) cycle();
    check("mid_phase", phase, 3);
    do_reset();
    run = 1'b0;
    count_period(-1, 4'd0, nr, ng, nb);
    check("mid_first_rgb", nr + ng + nb, 0);
    count_period(-1, 4'd0, nr, ng, nb);
    check("mid_load_r", nr, 15);
    check("mid_load_gb", ng + nb, 0);

    // Randomized run/step/bright/reset traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) run = ~run;
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) bright = PW'($urandom_range(0, Max));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
